// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter with a single-bit-step checker.
// The binary result, its valid flag and the step error are all produced one clock after the sample is accepted.
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray,
  input  logic             in_valid,
  output logic [WIDTH-1:0] bin,
  output logic             out_valid,
  output logic             step_err
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("gray_to_binary: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] bin_d,  bin_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic             hist_q;
  logic             out_valid_q;
  logic             step_err_d, step_err_q;
  logic             acc;

  // NOTE: every variable gets a default at the top of always_comb, so no path can leave it unassigned and infer a latch.
  always_comb begin
    bin_d = '0;
    acc   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ gray[i];
      bin_d[i] = acc;
    end
  end

  // Two or more differing bits <=> clearing the lowest set bit still leaves a bit set.
  always_comb begin
    diff       = gray ^ prev_q;
    step_err_d = hist_q & (|(diff & (diff - WIDTH'(1))));
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      prev_q      <= '0;
      hist_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      step_err_q  <= in_valid & step_err_d;
      if (in_valid) begin
        bin_q  <= bin_d;
        prev_q <= gray;
        hist_q <= 1'b1;
      end
    end
  end

  assign bin       = bin_q;
  assign out_valid = out_valid_q;
  assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray_to_binary.sv
// Scoreboard bench for gray_to_binary: a 4-bit and an 8-bit instance share clock and reset.
// Drivers push hand-computed results into queues; monitors pop and compare whenever out_valid is seen.
module tb_gray_to_binary;

  typedef struct {
    logic [7:0] bin;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray4 = '0;
  logic       in_valid4 = 1'b0;
  logic [3:0] bin4;
  logic       out_valid4, step_err4;
  logic [7:0] gray8 = '0;
  logic       in_valid8 = 1'b0;
  logic [7:0] bin8;
  logic       out_valid8, step_err8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gray_to_binary #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .gray(gray4), .in_valid(in_valid4),
    .bin(bin4), .out_valid(out_valid4), .step_err(step_err4)
  );

  gray_to_binary #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .gray(gray8), .in_valid(in_valid8),
    .bin(bin8), .out_valid(out_valid8), .step_err(step_err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge, half a cycle away from the register updates.
  always @(negedge clk) begin
    if (out_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("w4 unexpected out_valid", 32'(out_valid4), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4 bin", 32'(bin4), 32'(e.bin[3:0]));
        check("w4 step_err", 32'(step_err4), 32'(e.err));
      end
    end else begin
      check("w4 step_err without out_valid", 32'(step_err4), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (out_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 unexpected out_valid", 32'(out_valid8), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8 bin", 32'(bin8), 32'(e.bin));
        check("w8 step_err", 32'(step_err8), 32'(e.err));
      end
    end else begin
      check("w8 step_err without out_valid", 32'(step_err8), 32'd0);
    end
  end

  task automatic send4(input logic [3:0] g, input logic [3:0] b, input logic err);
    exp_t e;
    @(negedge clk);
    gray4     = g;
    in_valid4 = 1'b1;
    e.bin     = {4'b0, b};
    e.err     = err;
    q4.push_back(e);
  endtask

  task automatic send8(input logic [7:0] g, input logic [7:0] b, input logic err);
    exp_t e;
    @(negedge clk);
    gray8     = g;
    in_valid8 = 1'b1;
    e.bin     = b;
    e.err     = err;
    q8.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid4 = 1'b0;
      in_valid8 = 1'b0;
    end
  endtask

  // Full 4-bit Gray sequence; entry i converts to binary i.
  logic [3:0] seq4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    repeat (2) @(negedge clk);
    check("reset bin", 32'(bin4), 32'd0);
    check("reset out_valid", 32'(out_valid4), 32'd0);
    check("reset step_err", 32'(step_err4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) send4(seq4[i], 4'(i), 1'b0);

    // Wrap 1000 -> 0000, then a repeated code.
    send4(4'b0000, 4'd0, 1'b0);
    send4(4'b0000, 4'd0, 1'b0);

    // Two-bit jump, then a legal step.
    send4(4'b0011, 4'd2, 1'b1);
    send4(4'b0010, 4'd3, 1'b0);
    send4(4'b0110, 4'd4, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid4 = 1'b0;
      if (i > 0) begin
        check("gap out_valid", 32'(out_valid4), 32'd0);
        check("gap bin hold", 32'(bin4), 32'd4);
      end
    end
    @(negedge clk);
    check("gap end out_valid", 32'(out_valid4), 32'd0);
    check("gap end bin hold", 32'(bin4), 32'd4);
    gray4     = 4'b1100;
    in_valid4 = 1'b1;
    q4.push_back('{bin: 8'd8, err: 1'b1});

    // 1100 -> 0111 differs in three bits.
    send4(4'b0111, 4'd5, 1'b1);

    // Reset during a valid sample: the sample is discarded.
    @(negedge clk);
    rst       = 1'b1;
    gray4     = 4'b0101;
    in_valid4 = 1'b1;
    @(negedge clk);
    check("mid-reset bin", 32'(bin4), 32'd0);
    check("mid-reset out_valid", 32'(out_valid4), 32'd0);
    rst = 1'b0;
    gray4 = 4'b1111;
    q4.push_back('{bin: 8'd10, err: 1'b0});

    send4(4'b1110, 4'd11, 1'b0);
    send4(4'b0001, 4'd1, 1'b1);
    idle_cycles(1);

    // 8-bit instance: first sample since reset, then a 7-bit jump, then a single-bit step.
    send8(8'b1111_1111, 8'b1010_1010, 1'b0);
    send8(8'b1000_0000, 8'b1111_1111, 1'b1);
    send8(8'b0000_0000, 8'b0000_0000, 1'b0);
    idle_cycles(4);

    check("w4 scoreboard drained", 32'(q4.size()), 32'd0);
    check("w8 scoreboard drained", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
